// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter shared by an instruction-fetch port and a data port.
// At most one access is issued per cycle. The grant is combinational in the
// acceptance cycle, and read data returns one cycle later on the owning port.
// The starvation counter guarantees IF progress against a continuously
// requesting MEM port.
// Build option: define MEM_ARB_RR_EN to select round-robin arbitration between
// simultaneous requests. By default MEM has fixed priority over IF.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // instruction-fetch port (read only)
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // data port
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_rvalid,
  output logic [DATA_W-1:0] mem_rdata,
  // RAM side
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {StIdle, StRdIf, StRdMem} state_e;

  localparam logic [3:0] StarveLimit = 4'd8;

  state_e     state_q;
  logic [3:0] starve_q;
  logic       if_win;
  logic       mem_win;
  logic       starve;

`ifdef MEM_ARB_RR_EN
  // 1: MEM wins the next tie, 0: IF wins the next tie
  logic       rr_mem_q;
`endif

  assign starve = if_req && (starve_q >= StarveLimit);

  // Pick the single winner for this cycle. Nothing is granted while in reset.
  always_comb begin
    if_win  = 1'b0;
    mem_win = 1'b0;
    if (rst) begin
      if (if_req && mem_req) begin
        if (starve) begin
          if_win = 1'b1;
        end else begin
`ifdef MEM_ARB_RR_EN
          if (rr_mem_q) begin
            mem_win = 1'b1;
          end else begin
            if_win = 1'b1;
          end
`else
          mem_win = 1'b1;
`endif
        end
      end else begin
        if_win  = if_req;
        mem_win = mem_req;
      end
    end
  end

  // Drive the RAM with the winning request. Idle cycles hold all RAM outputs at 0.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    if (if_win) begin
      ram_addr = if_addr;
      ram_re   = 1'b1;
    end else if (mem_win) begin
      ram_addr = mem_addr;
      ram_we   = mem_we;
      ram_re   = ~mem_we;
      if (mem_we) begin
        ram_wdata = mem_wdata;
      end
    end
  end

  assign if_gnt  = if_win;
  assign mem_gnt = mem_win;

  // Return the RAM data to the port that owns the read in flight. Data is 0 otherwise.
  always_comb begin
    if_rvalid  = (state_q == StRdIf);
    mem_rvalid = (state_q == StRdMem);
    if_rdata   = if_rvalid  ? ram_rdata : '0;
    mem_rdata  = mem_rvalid ? ram_rdata : '0;
  end

  // Track the read in flight, IF starvation, and the tie-break pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      starve_q <= 4'd0;
`ifdef MEM_ARB_RR_EN
      rr_mem_q <= 1'b0;
`endif
    end else begin
      if (if_win) begin
        state_q <= StRdIf;
      end else if (mem_win && !mem_we) begin
        state_q <= StRdMem;
      end else begin
        state_q <= StIdle;
      end

      if (if_win || !if_req) begin
        starve_q <= 4'd0;
      end else if (starve_q != 4'hF) begin
        starve_q <= starve_q + 4'd1;
      end

`ifdef MEM_ARB_RR_EN
      if (if_win) begin
        rr_mem_q <= 1'b1;
      end else if (mem_win) begin
        rr_mem_q <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. A small RAM model serves the DUT. Expected read
// data is pushed to per-port queues when a grant is expected and popped when
// rvalid is due.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata;

  logic        ram_init;
  logic [31:0] ram_arr [64];
  logic [31:0] ref_mem [64];
  logic [31:0] if_q [$];
  logic [31:0] mem_q [$];
  logic        exp_if_rv;
  logic        exp_mem_rv;
  int          total;
  int          bad;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .ram_re     (ram_re),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return (i == 16) ? 32'hDEADBEEF : (32'hC0DE_0000 | 32'(i));
  endfunction

  // Synchronous single-port RAM: read data appears one cycle after ram_re.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 64; i++) ram_arr[i] <= init_val(i);
    end else begin
      if (ram_we) ram_arr[ram_addr[5:0]] <= ram_wdata;
      if (ram_re) ram_rdata <= ram_arr[ram_addr[5:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".flags"}, 32'({if_gnt, mem_gnt, ram_we, ram_re, if_rvalid, mem_rvalid}), 32'd0);
    chk({tag, ".ram_addr"}, ram_addr, 32'd0);
    chk({tag, ".ram_wdata"}, ram_wdata, 32'd0);
    chk({tag, ".if_rdata"}, if_rdata, 32'd0);
    chk({tag, ".mem_rdata"}, mem_rdata, 32'd0);
  endtask

  // One clock cycle: drive the inputs, check at the negedge, update the scoreboard.
  task automatic step(input logic ir, input logic [31:0] ia, input logic mr, input logic mw,
                      input logic [31:0] ma, input logic [31:0] md,
                      input logic eig, input logic emg, input string tag);
    logic [31:0] ea;
    logic [31:0] ewd;
    logic        er;
    logic        ew;
    logic [31:0] ed;
    if_req    = ir;
    if_addr   = ia;
    mem_req   = mr;
    mem_we    = mw;
    mem_addr  = ma;
    mem_wdata = md;
    @(negedge clk);
    chk({tag, ".if_gnt"}, 32'(if_gnt), 32'(eig));
    chk({tag, ".mem_gnt"}, 32'(mem_gnt), 32'(emg));
    ea = '0; ewd = '0; er = 1'b0; ew = 1'b0;
    if (eig) begin
      ea = ia; er = 1'b1;
    end else if (emg) begin
      ea = ma; ew = mw; er = ~mw; ewd = mw ? md : 32'd0;
    end
    chk({tag, ".ram_addr"}, ram_addr, ea);
    chk({tag, ".ram_re"}, 32'(ram_re), 32'(er));
    chk({tag, ".ram_we"}, 32'(ram_we), 32'(ew));
    if (!er) chk({tag, ".ram_wdata"}, ram_wdata, ewd);
    chk({tag, ".if_rvalid"}, 32'(if_rvalid), 32'(exp_if_rv));
    chk({tag, ".mem_rvalid"}, 32'(mem_rvalid), 32'(exp_mem_rv));
    ed = 32'd0;
    if (exp_if_rv) ed = if_q.pop_front();
    chk({tag, ".if_rdata"}, if_rdata, ed);
    ed = 32'd0;
    if (exp_mem_rv) ed = mem_q.pop_front();
    chk({tag, ".mem_rdata"}, mem_rdata, ed);
    exp_if_rv  = eig;
    exp_mem_rv = emg && !mw;
    if (eig) if_q.push_back(ref_mem[ia[5:0]]);
    if (emg && !mw) mem_q.push_back(ref_mem[ma[5:0]]);
    if (emg && mw) ref_mem[ma[5:0]] = md;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    step(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    int ma_i;
    logic eig;
    total = 0;
    bad = 0;
    exp_if_rv = 1'b0;
    exp_mem_rv = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    // Reset with both ports requesting: nothing may leak out.
    ram_init = 1'b1;
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h10;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h20; mem_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk_zero("reset_a");
    @(negedge clk);
    chk_zero("reset_b");
    @(posedge clk);
    #1;
    rst = 1'b1;
    ram_init = 1'b0;

    // Single IF read in the first cycle out of reset.
    step(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "if_rd");
    idle("if_rv");
    idle("if_rv_off");

    // MEM write then read-back, back to back.
    step(1'b0, 32'd0, 1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 1'b1, "mem_wr");
    step(1'b0, 32'd0, 1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 1'b1, "mem_rd");
    idle("mem_rv");
    idle("mem_rv_off");

    // Alternating single-port reads every cycle.
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) step(1'b1, 32'(k + 1), 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "alt_if");
      else step(1'b0, 32'd0, 1'b1, 1'b0, 32'(k + 8), 32'd0, 1'b0, 1'b1, "alt_mem");
    end
    idle("alt_drain");
    idle("alt_quiet");

    // Reset in the cycle after an IF grant discards the read in flight.
    step(1'b1, 32'h10, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, "rst_if_rd");
    rst = 1'b0;
    if_req = 1'b1;
    mem_req = 1'b1;
    mem_we = 1'b0;
    @(negedge clk);
    chk_zero("rst_mid");
    if_q.delete();
    mem_q.delete();
    exp_if_rv = 1'b0;
    exp_mem_rv = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle("post_rst_a");
    idle("post_rst_b");

    // Both ports request continuously from a fresh arbitration state.
    ma_i = 0;
    for (int c = 0; c < 20; c++) begin
`ifdef MEM_ARB_RR_EN
      eig = (c % 2 == 0);
`else
      eig = (c % 9 == 8);
`endif
      step(1'b1, 32'h10, 1'b1, 1'b0, 32'(32'h30 + ma_i), 32'd0, eig, ~eig, "contend");
      if (!eig) ma_i++;
    end
    idle("contend_drain");
    idle("contend_quiet");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
